// File: rtl/minmax_tree_pipe_if.sv
// Stream interface for minmax_tree_pipe: input beat side and result side.
// master = producer/consumer (bench) view, slave = reducer view.
interface minmax_tree_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4
);
    localparam int IDX_W = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  in_max;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_value;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_max;

    modport master (
        output in_valid, in_data, in_max, out_ready,
        input  in_ready, out_valid, out_value, out_idx, out_max
    );

    modport slave (
        input  in_valid, in_data, in_max, out_ready,
        output in_ready, out_valid, out_value, out_idx, out_max
    );
endinterface

// File: rtl/minmax_tree_pipe.sv
// Streaming pipelined min/max reducer over N_IN lanes, one binary-tree level per
// register stage. Define MINMAX_SIGNED_EN to treat lanes as two's-complement signed.
module minmax_tree_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4
) (
    input logic               clk,
    input logic               rst_n,
    minmax_tree_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(N_IN);
    localparam int IDX_W  = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1;

    typedef logic [WIDTH-1:0] val_t;
    typedef logic [IDX_W-1:0] idx_t;

    // Number of live elements at tree level k (level 0 is the input).
    function automatic int lane_cnt(int k);
        return (N_IN + (1 << k) - 1) >> k;
    endfunction

    // True when the higher-index element wins; ties stay with the lower index.
    function automatic logic take_hi(val_t lo, val_t hi, logic is_max);
`ifdef MINMAX_SIGNED_EN
        return is_max ? ($signed(hi) > $signed(lo)) : ($signed(hi) < $signed(lo));
`else
        return is_max ? (hi > lo) : (hi < lo);
`endif
    endfunction

    logic              adv;
    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] mode_q;
    val_t              val_q   [LEVELS][N_IN];
    idx_t              idx_q   [LEVELS][N_IN];
    val_t              val_d   [LEVELS][N_IN];
    idx_t              idx_d   [LEVELS][N_IN];
    // Source of each tree level; the extra slot is a zero pad so an odd tail pairs safely.
    val_t              tree_val  [LEVELS][N_IN+1];
    idx_t              tree_idx  [LEVELS][N_IN+1];
    logic [LEVELS-1:0] tree_mode;

    // Global enable: everything advances unless a result is waiting on the consumer.
    assign adv          = !valid_q[LEVELS-1] | bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = valid_q[LEVELS-1];
    assign bus.out_value = val_q[LEVELS-1][0];
    assign bus.out_idx   = idx_q[LEVELS-1][0];
    assign bus.out_max   = mode_q[LEVELS-1];

    // Present the input beat and each stage's registers as the inputs of the next level.
    always_comb begin
        for (int k = 0; k < LEVELS; k++) begin
            for (int i = 0; i <= N_IN; i++) begin
                tree_val[k][i] = '0;
                tree_idx[k][i] = '0;
            end
        end
        tree_mode = '0;
        for (int i = 0; i < N_IN; i++) begin
            tree_val[0][i] = bus.in_data[i*WIDTH +: WIDTH];
            tree_idx[0][i] = idx_t'(i);
        end
        tree_mode[0] = bus.in_max;
        for (int k = 1; k < LEVELS; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                tree_val[k][i] = val_q[k-1][i];
                tree_idx[k][i] = idx_q[k-1][i];
            end
            tree_mode[k] = mode_q[k-1];
        end
    end

    // Pairwise compare at each level; an unpaired last element passes through.
    always_comb begin
        for (int k = 0; k < LEVELS; k++) begin
            for (int j = 0; j < N_IN; j++) begin
                val_d[k][j] = '0;
                idx_d[k][j] = '0;
            end
            for (int j = 0; j < lane_cnt(k + 1); j++) begin
                if ((2 * j + 1 < lane_cnt(k)) &&
                    take_hi(tree_val[k][2*j], tree_val[k][2*j+1], tree_mode[k])) begin
                    val_d[k][j] = tree_val[k][2*j+1];
                    idx_d[k][j] = tree_idx[k][2*j+1];
                end else begin
                    val_d[k][j] = tree_val[k][2*j];
                    idx_d[k][j] = tree_idx[k][2*j];
                end
            end
        end
    end

    // Pipeline registers: all stages shift together when enabled, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            mode_q  <= '0;
            for (int k = 0; k < LEVELS; k++) begin
                for (int j = 0; j < N_IN; j++) begin
                    val_q[k][j] <= '0;
                    idx_q[k][j] <= '0;
                end
            end
        end else if (adv) begin
            valid_q[0] <= bus.in_valid;
            mode_q[0]  <= bus.in_max;
            for (int k = 1; k < LEVELS; k++) begin
                valid_q[k] <= valid_q[k-1];
                mode_q[k]  <= mode_q[k-1];
            end
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end
endmodule
